// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory responder.
//   - RV32I load/store funct3 codes
//   - responder FSM state encoding
//   - maximum supported response latency
//   - misalignment predicate, used when DMEM_MISALIGN_TRAP_EN is defined
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_t;

  // Halfword accesses need addr[0]=0 and word accesses need addr[1:0]=0.
  // LHU exists only for loads, so funct3=101 on a store is never flagged.
  function automatic logic is_misaligned(input logic is_load,
                                         input logic [2:0] f3,
                                         input logic [1:0] a);
    logic m;
    m = 1'b0;
    if (f3 == F3_H || (is_load && f3 == F3_HU)) m = a[0];
    else if (f3 == F3_W)                        m = (a != 2'b00);
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word RAM with synchronous write and combinational read.
//   clk   : clock
//   be    : per-byte write enable; all-zero means no write this cycle
//   widx  : word index for the write
//   wdata : write data, already placed in its byte lanes
//   ridx  : word index for the read
//   rdata : word at ridx, available in the same cycle
// Contents are not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder at the far end of the MEM-stage
// load/store interface. Loads complete after LATENCY cycles; stores are
// absorbed in one cycle.
//   clk, rst   : clock; asynchronous active-low reset
//   load       : load request, held with stable addr/funct3 until dmem_valid
//   store      : one-cycle store request, honoured only in IDLE without load
//   funct3     : RV32I access size/sign
//   addr       : byte address; bits above the RAM size are ignored (wrap)
//   wdata      : store data, LSB-aligned
//   rdata      : extended load result; holds after RESP until the next RESP
//   dmem_valid : one-cycle load completion pulse
//   dbg_state  : current FSM state (dm_state_t encoding)
//   misalign   : misaligned-access flag, only with DMEM_MISALIGN_TRAP_EN
// Handshake: a load is accepted at the first edge where load=1 in IDLE;
// dmem_valid then pulses for exactly one cycle LATENCY cycles later, and load
// is not sampled during that RESP cycle, so a request held through its
// completion is never accepted twice.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        dmem_valid,
  output logic [1:0]  dbg_state
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dm_state_t        state;
  logic [3:0]       cnt;
  logic [IDX_W+1:0] lat_addr;
  logic [2:0]       lat_f3;
  logic [31:0]      rdata_q;
  logic [31:0]      ram_rdata;
  logic [31:0]      ld_shift;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;
  logic             st_go;
  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^addr[31:IDX_W+2];

  assign st_go = store && !load && (state == DM_IDLE);

  // Load path: operate on the latched request; memory cannot change while a
  // load is outstanding because stores are only taken in IDLE.
  always_comb begin
    ld_shift = ram_rdata >> {lat_addr[1:0], 3'b000};
    ld_half  = lat_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (lat_f3)
      F3_B:    ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_ext = ram_rdata;
      F3_BU:   ld_ext = {24'b0, ld_shift[7:0]};
      F3_HU:   ld_ext = {16'b0, ld_half};
      default: ld_ext = 32'b0;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    if (is_misaligned(1'b1, lat_f3, lat_addr[1:0])) ld_ext = 32'b0;
`endif
  end

  // Store path: replicate the data across lanes and let the byte enables
  // pick the target lane(s).
  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'b0;
    case (funct3)
      F3_B: begin
        st_be   = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      F3_H: begin
        st_be   = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      F3_W: begin
        st_be   = 4'b1111;
        st_data = wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = 32'b0;
      end
    endcase
    if (!st_go) st_be = 4'b0000;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (is_misaligned(1'b0, funct3, addr[1:0])) st_be = 4'b0000;
`endif
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .be    (st_be),
    .widx  (addr[IDX_W+1:2]),
    .wdata (st_data),
    .ridx  (lat_addr[IDX_W+1:2]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DM_IDLE;
      cnt      <= 4'd0;
      lat_addr <= '0;
      lat_f3   <= 3'b0;
      rdata_q  <= 32'b0;
    end else begin
      case (state)
        DM_IDLE: begin
          if (load) begin
            lat_addr <= addr[IDX_W+1:0];
            lat_f3   <= funct3;
            cnt      <= 4'(LATENCY - 1);
            state    <= (LATENCY == 1) ? DM_RESP : DM_WAIT;
          end
        end
        DM_WAIT: begin
          cnt <= cnt - 4'd1;
          // The counter reaches 0 at this edge.
          if (cnt <= 4'd1) state <= DM_RESP;
        end
        DM_RESP: begin
          rdata_q <= ld_ext;
          state   <= DM_IDLE;
        end
        default: state <= DM_IDLE;
      endcase
    end
  end

  // Outputs derive from state so an asynchronous reset clears them at once.
  assign dmem_valid = (state == DM_RESP);
  assign rdata      = (state == DM_RESP) ? ld_ext : rdata_q;
  assign dbg_state  = state;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic st_mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_mis_q <= 1'b0;
    else      st_mis_q <= st_go && is_misaligned(1'b0, funct3, addr[1:0]);
  end

  assign misalign = st_mis_q ||
                    ((state == DM_RESP) && is_misaligned(1'b1, lat_f3, lat_addr[1:0]));
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder with default
// parameters (DEPTH_WORDS=1024, LATENCY=2). The reference model is a
// 4096-byte array updated and read with plain byte arithmetic. Covers the
// misalign port when DMEM_MISALIGN_TRAP_EN is defined.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        store = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'b0;
  logic [31:0] wdata = 32'b0;
  logic [31:0] rdata;
  logic        dmem_valid;
  logic [1:0]  dbg_state;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .store      (store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .dmem_valid (dmem_valid),
    .dbg_state  (dbg_state)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          pulse_cnt = 0;
  int          loads_done = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mem_b [4096];

  always @(negedge clk) if (dmem_valid === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_mis(input logic is_load, input logic [2:0] f3,
                                     input logic [31:0] a);
    logic m;
    m = 1'b0;
    if (f3 == 3'b001 || (is_load && f3 == 3'b101)) m = a[0];
    if (f3 == 3'b010) m = (a[1:0] != 2'b00);
`ifndef DMEM_MISALIGN_TRAP_EN
    m = 1'b0;
`endif
    return m;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int b, h, w;
    b = int'(a[11:0]);
    h = b - (b % 2);
    w = b - (b % 4);
    if (model_mis(1'b1, f3, a)) return 32'b0;
    case (f3)
      3'b000:  return {{24{mem_b[b][7]}}, mem_b[b]};
      3'b001:  return {{16{mem_b[h+1][7]}}, mem_b[h+1], mem_b[h]};
      3'b010:  return {mem_b[w+3], mem_b[w+2], mem_b[w+1], mem_b[w]};
      3'b100:  return {24'b0, mem_b[b]};
      3'b101:  return {16'b0, mem_b[h+1], mem_b[h]};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int b, h, w;
    b = int'(a[11:0]);
    h = b - (b % 2);
    w = b - (b % 4);
    if (model_mis(1'b0, f3, a)) return;
    case (f3)
      3'b000: mem_b[b] = d[7:0];
      3'b001: begin mem_b[h] = d[7:0]; mem_b[h+1] = d[15:8]; end
      3'b010: begin
        mem_b[w] = d[7:0];   mem_b[w+1] = d[15:8];
        mem_b[w+2] = d[23:16]; mem_b[w+3] = d[31:24];
      end
      default: ;
    endcase
  endtask

  // ---------------- driver tasks (start and end just after a negedge) ----------------
  task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    logic em;
    em = model_mis(1'b0, f3, a);
    model_store(f3, a, d);
    load = 1'b0; store = 1'b1; addr = a; funct3 = f3; wdata = d;
    @(negedge clk);
    store = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    check("st_misalign", 32'(misalign), 32'(em));
`else
    if (em) check("st_model_mis", 32'(em), 32'd0);
`endif
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input bit hold,
                         input int exp_wait, output logic [31:0] got);
    int n;
    logic [31:0] e;
    logic em;
    n = 0;
    load = 1'b1; store = 1'b0; addr = a; funct3 = f3;
    exp_q.push_back(model_load(f3, a));
    em = model_mis(1'b1, f3, a);
    do begin
      @(negedge clk);
      n++;
    end while (dmem_valid !== 1'b1 && n < 64);
    check("load_wait", 32'(n), 32'(exp_wait));
    e = exp_q.pop_front();
    got = rdata;
    if (dmem_valid === 1'b1) begin
      loads_done++;
      check("load_rdata", rdata, e);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("ld_misalign", 32'(misalign), 32'(em));
`else
      if (em) check("ld_model_mis", 32'(em), 32'd0);
`endif
    end
    if (!hold) begin
      load = 1'b0;
      @(negedge clk);
      check("valid_one_cycle", 32'(dmem_valid), 32'd0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] got;
    logic [31:0] r;
    int p0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(dmem_valid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(DM_IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Fill the whole RAM so model and DUT agree everywhere.
    for (int i = 0; i < 1024; i++) do_store(32'(i * 4), 3'b010, $urandom());

    // LW after store, single pulse, back to IDLE
    do_store(32'h10, 3'b010, 32'hDEADBEEF);
    p0 = pulse_cnt;
    do_load(32'h10, 3'b010, 1'b0, LAT, got);
    check("lw_const", got, 32'hDEADBEEF);
    check("lw_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("lw_idle", 32'(dbg_state), 32'(DM_IDLE));

    // Byte store / signed and unsigned byte loads
    do_store(32'h23, 3'b000, 32'h00000080);
    do_load(32'h23, 3'b000, 1'b0, LAT, got);
    check("lb_const", got, 32'hFFFFFF80);
    do_load(32'h23, 3'b100, 1'b0, LAT, got);
    check("lbu_const", got, 32'h00000080);

    // Halfword store into the upper half
    r = model_load(3'b010, 32'h40);
    do_store(32'h42, 3'b001, 32'h00008001);
    do_load(32'h42, 3'b001, 1'b0, LAT, got);
    check("lh_const", got, 32'hFFFF8001);
    do_load(32'h40, 3'b010, 1'b0, LAT, got);
    check("lw_upper", {16'b0, got[31:16]}, 32'h00008001);
    check("lw_lower", {16'b0, got[15:0]}, {16'b0, r[15:0]});

    // Back-to-back loads with load held continuously
    p0 = pulse_cnt;
    do_load(32'h100, 3'b010, 1'b1, LAT, got);
    do_load(32'h104, 3'b010, 1'b1, LAT + 1, got);
    do_load(32'h108, 3'b010, 1'b0, LAT + 1, got);
    check("b2b_pulses", 32'(pulse_cnt - p0), 32'd3);

    // rdata holds after RESP
    r = rdata;
    repeat (2) @(negedge clk);
    check("rdata_hold", rdata, r);

    // load and store together in IDLE: store dropped
    load = 1'b1; store = 1'b1; addr = 32'h20; funct3 = 3'b010; wdata = 32'h12345678;
    @(negedge clk);
    store = 1'b0;
    do_load(32'h20, 3'b010, 1'b0, LAT - 1, got);

    // Reset during WAIT: no pulse, FSM back to IDLE
    p0 = pulse_cnt;
    load = 1'b1; addr = 32'h30; funct3 = 3'b010;
    @(posedge clk); #1;
    check("mid_wait_state", 32'(dbg_state), 32'(DM_WAIT));
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(dmem_valid), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(DM_IDLE));
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Reset during RESP clears dmem_valid asynchronously
    load = 1'b1; addr = 32'h34; funct3 = 3'b010;
    repeat (LAT) @(posedge clk);
    #1;
    check("resp_valid", 32'(dmem_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("resp_rst_valid", 32'(dmem_valid), 32'd0);
    load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fresh load after reset; upper address bits alias
    do_load(32'h1010, 3'b010, 1'b0, LAT, got);
    check("alias_const", got, 32'hDEADBEEF);
    do_store(32'h2014, 3'b010, 32'hA5A55A5A);
    do_load(32'h14, 3'b010, 1'b0, LAT, got);
    check("alias_store", got, 32'hA5A55A5A);

`ifdef DMEM_MISALIGN_TRAP_EN
    do_load(32'h12, 3'b010, 1'b0, LAT, got);
    check("mis_lw_rdata", got, 32'd0);
    do_store(32'h12, 3'b010, 32'h11111111);
    @(negedge clk);
    check("mis_st_pulse_end", 32'(misalign), 32'd0);
    do_load(32'h10, 3'b010, 1'b0, LAT, got);
    check("mis_st_nowrite", got, 32'hDEADBEEF);
`endif

    // Randomized mix of stores and loads
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(0, 16383));
      if ($urandom_range(0, 1) == 1)
        do_store(ra, 3'($urandom_range(0, 3)), $urandom());
      else
        do_load(ra, 3'($urandom_range(0, 7)), 1'b0, LAT, got);
    end

    check("pulse_total", 32'(pulse_cnt), 32'(loads_done));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core. It sits at the far end of the load/store interface driven by the MEM stage and answers each load after a configurable number of wait states. It produces the `dmem_valid` handshake that the fetch program counter and pipeline stall on while a load is outstanding. Stores are absorbed in a single cycle without stalling.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; must be a power of two.
- `LATENCY`, 2: cycles from load acceptance to `dmem_valid`; legal range 1..15.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-low.
- `load` input 1: load request; the core holds it high with stable `addr`/`funct3` until it samples `dmem_valid`.
- `store` input 1: store request, one cycle.
- `funct3` input 3: access size/sign (RV32I encoding).
- `addr` input 32: byte address.
- `wdata` input 32: store data, LSB-aligned.
- `rdata` output 32: extended load result.
- `dmem_valid` output 1: one-cycle completion pulse for a load.
- `misalign` output 1: misaligned-access flag; present only with `DMEM_MISALIGN_TRAP_EN`.

## Operation
- Three-state FSM: IDLE, WAIT, RESP.
- IDLE:
  - `load`=1 at a clock edge: latch `addr`/`funct3`, load the counter with LATENCY-1.
  - Next state is WAIT, or RESP directly if LATENCY=1.
- WAIT: decrement the counter each cycle; go to RESP on the edge where the counter reaches 0.
- RESP:
  - `dmem_valid`=1 and `rdata` valid for exactly one cycle.
  - Unconditional return to IDLE.
  - `load` is not re-sampled in RESP, so a held request is never accepted twice.
- Stores:
  - Accepted only in IDLE with `load`=0; the write completes at that edge.
  - No stall and no `dmem_valid` pulse.
  - `store` outside IDLE is ignored; the pipeline guarantees it does not occur.
- `load` and `store` high together in IDLE: load wins, store dropped.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so accesses wrap modulo DEPTH_WORDS*4 bytes.
- Load extension by `funct3`:
  - 000 LB: sign-extend byte `addr[1:0]`.
  - 001 LH: sign-extend half `addr[1]`.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other codes return 0.
- Store by `funct3`:
  - 000 SB: byte lane `addr[1:0]` from `wdata[7:0]`.
  - 001 SH: half lane `addr[1]` from `wdata[15:0]`.
  - 010 SW: full word.
  - Other codes write nothing.
- Store-then-load to the same address: the load returns the new data. The write lands before the load can be accepted.

## Timing
- Reset values: `dmem_valid`=0, `rdata`=0, `misalign`=0, FSM in IDLE, counter 0. Memory contents are not reset.
- Load latency: `load` sampled at edge N, `dmem_valid` high in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles of stall.
- Back-to-back loads: the next load is accepted at the first edge after RESP. Throughput is one load per LATENCY+1 cycles.
- `rdata` holds its last value after RESP until the next RESP.
- Reset asserted mid-load: the FSM drops to IDLE and `dmem_valid` clears immediately (asynchronously). The pending load is abandoned; the core re-issues it after reset.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - The `misalign` port exists.
  - Misaligned LH/LHU/SH (`addr[0]`=1) or LW/SW (`addr[1:0]`≠0) are detected.
  - A misaligned load completes with normal latency, with `rdata`=0 and `misalign`=1 alongside `dmem_valid`.
  - A misaligned store writes nothing and pulses `misalign` for one cycle after the store edge.
- Undefined:
  - No `misalign` port.
  - Halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`.

## Structure
- `dmem_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - FSM state enum (`DM_IDLE`, `DM_WAIT`, `DM_RESP`).
  - Max LATENCY constant.
- Sub-module `dmem_array`:
  - Synchronous-write, combinational-read word RAM with 4-bit byte enable.
  - Lane shifting, extension and the FSM stay in `dmem_responder`.

## Test plan
- Reset, LATENCY=2: hold `load`=1, `funct3`=010, `addr`=0x10 to word 0x10 preloaded with 0xDEADBEEF -> `dmem_valid` pulses exactly once, 2 cycles after acceptance, `rdata`=0xDEADBEEF, then IDLE.
- SB 0x80 to 0x23, then LB 0x23 -> `rdata`=0xFFFFFF80; LBU 0x23 -> `rdata`=0x00000080.
- SH 0x8001 to 0x42, then LH 0x42 -> `rdata`=0xFFFF8001; LW 0x40 -> upper half 0x8001 with the lower half unchanged.
- Three back-to-back loads with `load` held continuously -> exactly three `dmem_valid` pulses at a spacing of 3 cycles, no duplicate acceptance.
- Reset pulse during WAIT -> `dmem_valid` never asserts; after release a fresh load completes normally. Address 0x1000+0x10 with DEPTH_WORDS=1024 aliases to 0x10.
- With the macro defined: LW 0x12 -> `misalign`=1, `rdata`=0 with `dmem_valid`; SW 0x12 -> memory unchanged and `misalign` pulses once.
